// File: rtl/vp_pipe_pkg.sv
// Shared definitions for the vp_pipe video processor: operation encodings,
// luma coefficients and the pipeline depth.
package vp_pkg;

  typedef enum logic [1:0] {
    VP_PASS = 2'd0,
    VP_GRAY = 2'd1,
    VP_BIN  = 2'd2,
    VP_INV  = 2'd3
  } vp_mode_e;

  // Coefficients sum to 256, so Y = sum >> 8 always fits in one channel.
  localparam int VP_COEF_R = 77;
  localparam int VP_COEF_G = 150;
  localparam int VP_COEF_B = 29;

  localparam int VP_LAT = 3;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } vp_sync_t;

endpackage

// File: rtl/vp_pipe_if.sv
// Video stream, per-frame configuration and geometry bundle between the
// HDMI input stage, vp_pipe and the HDMI output stage.
interface vp_pipe_if #(
  parameter int CH_W  = 8,
  parameter int N_CH  = 3,
  parameter int CNT_W = 12
);

  logic                   de_in;
  logic                   h_sync_in;
  logic                   v_sync_in;
  logic [N_CH*CH_W-1:0]   pixel_in;
  logic [1:0]             mode;
  logic [CH_W-1:0]        thr;

  logic                   de_out;
  logic                   h_sync_out;
  logic                   v_sync_out;
  logic [N_CH*CH_W-1:0]   pixel_out;
  logic [CNT_W-1:0]       frame_width;
  logic [CNT_W-1:0]       frame_height;
  logic [15:0]            frame_cnt;
  logic                   geom_valid;

  modport slave (
    input  de_in, h_sync_in, v_sync_in, pixel_in, mode, thr,
    output de_out, h_sync_out, v_sync_out, pixel_out,
           frame_width, frame_height, frame_cnt, geom_valid
  );

  modport master (
    output de_in, h_sync_in, v_sync_in, pixel_in, mode, thr,
    input  de_out, h_sync_out, v_sync_out, pixel_out,
           frame_width, frame_height, frame_cnt, geom_valid
  );

endinterface

// File: rtl/vp_pipe_luma.sv
// Two-stage RGB to luma: stage 1 registers the weighted products, stage 2
// registers their sum; Y is the sum with the 8 fraction bits dropped.
module vp_luma
  import vp_pkg::*;
#(
  parameter int CH_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH_W-1:0] r_i,
  input  logic [CH_W-1:0] g_i,
  input  logic [CH_W-1:0] b_i,
  output logic [CH_W-1:0] y_o
);

  localparam int PROD_W = CH_W + 8;
  localparam int SUM_W  = CH_W + 10;

  logic [PROD_W-1:0] prod_r_q;
  logic [PROD_W-1:0] prod_g_q;
  logic [PROD_W-1:0] prod_b_q;
  logic [SUM_W-1:0]  sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r_q <= '0;
      prod_g_q <= '0;
      prod_b_q <= '0;
      sum_q    <= '0;
    end else begin
      prod_r_q <= PROD_W'(r_i) * PROD_W'(VP_COEF_R);
      prod_g_q <= PROD_W'(g_i) * PROD_W'(VP_COEF_G);
      prod_b_q <= PROD_W'(b_i) * PROD_W'(VP_COEF_B);
      sum_q    <= SUM_W'(prod_r_q) + SUM_W'(prod_g_q) + SUM_W'(prod_b_q);
    end
  end

  assign y_o = CH_W'(sum_q >> 8);

endmodule

// File: rtl/vp_pipe.sv
// Per-frame selectable pixel operation (pass/gray/binarise/invert) with a
// fixed 3-cycle latency on pixel and syncs, plus frame geometry measurement.
module vp_pipe
  import vp_pkg::*;
#(
  parameter int CH_W    = 8,
  parameter int N_CH    = 3,
  parameter int CNT_W   = 12,
  parameter int THR_RST = 128
) (
  input  logic     clk,
  input  logic     rst_n,
  vp_pipe_if.slave vid
);

  localparam int PIX_W = N_CH * CH_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  vp_sync_t         sync_in;
  vp_sync_t         sync_s1_q, sync_s2_q, sync_s3_q;
  logic [PIX_W-1:0] pix_s1_q, pix_s2_q, pix_s3_q, pix_d;
  vp_mode_e         mode_q, mode_s1_q, mode_s2_q;
  logic [CH_W-1:0]  thr_q, thr_s1_q, thr_s2_q;
  logic [CH_W-1:0]  luma_y;
  logic             frame_start;
  logic             de_fall;
  logic             y_ge_thr;

  assign sync_in = {vid.de_in, vid.h_sync_in, vid.v_sync_in};

  // Stage-1 sync register doubles as the edge-detect history of de and vsync.
  assign frame_start = vid.v_sync_in & ~sync_s1_q.vs;
  assign de_fall     = ~vid.de_in & sync_s1_q.de;

  vp_luma #(.CH_W(CH_W)) u_luma (
    .clk   (clk),
    .rst_n (rst_n),
    .r_i   (vid.pixel_in[(N_CH-1)*CH_W +: CH_W]),
    .g_i   (vid.pixel_in[(N_CH-2)*CH_W +: CH_W]),
    .b_i   (vid.pixel_in[(N_CH-3)*CH_W +: CH_W]),
    .y_o   (luma_y)
  );

  // Config travels with its pixel so a frame-start switch only touches new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= VP_PASS;
      thr_q     <= CH_W'(THR_RST);
      sync_s1_q <= '0;
      sync_s2_q <= '0;
      sync_s3_q <= '0;
      pix_s1_q  <= '0;
      pix_s2_q  <= '0;
      pix_s3_q  <= '0;
      mode_s1_q <= VP_PASS;
      mode_s2_q <= VP_PASS;
      thr_s1_q  <= '0;
      thr_s2_q  <= '0;
    end else begin
      if (frame_start) begin
        mode_q <= vp_mode_e'(vid.mode);
        thr_q  <= vid.thr;
      end
      sync_s1_q <= sync_in;
      pix_s1_q  <= vid.pixel_in;
      mode_s1_q <= mode_q;
      thr_s1_q  <= thr_q;
      sync_s2_q <= sync_s1_q;
      pix_s2_q  <= pix_s1_q;
      mode_s2_q <= mode_s1_q;
      thr_s2_q  <= thr_s1_q;
      sync_s3_q <= sync_s2_q;
      pix_s3_q  <= pix_d;
    end
  end

  assign y_ge_thr = (luma_y >= thr_s2_q);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [CH_W-1:0] ch_in;
    logic [CH_W-1:0] ch_out;

    assign ch_in = pix_s2_q[gi*CH_W +: CH_W];

    always_comb begin
      ch_out = ch_in;
      case (mode_s2_q)
        VP_PASS: ch_out = ch_in;
        VP_GRAY: ch_out = luma_y;
        VP_BIN:  ch_out = {CH_W{y_ge_thr}};
        VP_INV:  ch_out = ~ch_in;
        default: ch_out = ch_in;
      endcase
    end

    assign pix_d[gi*CH_W +: CH_W] = sync_s2_q.de ? ch_out : '0;
  end

  logic [CNT_W-1:0] x_cnt_q, x_cnt_d;
  logic [CNT_W-1:0] y_cnt_q, y_cnt_d;
  logic [CNT_W-1:0] line_w_q, line_w_d;
  logic [CNT_W-1:0] frame_width_q, frame_width_d;
  logic [CNT_W-1:0] frame_height_q, frame_height_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             geom_valid_q, geom_valid_d;

  // Line bookkeeping runs before the frame-start capture so a line ending on
  // the vsync edge is still part of the measured frame.
  always_comb begin
    x_cnt_d        = x_cnt_q;
    y_cnt_d        = y_cnt_q;
    line_w_d       = line_w_q;
    frame_width_d  = frame_width_q;
    frame_height_d = frame_height_q;
    frame_cnt_d    = frame_cnt_q;
    geom_valid_d   = geom_valid_q;

    if (vid.de_in && (x_cnt_q != CNT_MAX)) begin
      x_cnt_d = x_cnt_q + 1'b1;
    end

    if (de_fall) begin
      line_w_d = x_cnt_q;
      x_cnt_d  = '0;
      if (y_cnt_q != CNT_MAX) begin
        y_cnt_d = y_cnt_q + 1'b1;
      end
    end

    if (frame_start) begin
      frame_width_d  = line_w_d;
      frame_height_d = y_cnt_d;
      y_cnt_d        = '0;
      frame_cnt_d    = frame_cnt_q + 16'd1;
      // The frame before the first edge may be partial; trust the second.
      geom_valid_d   = geom_valid_q | (frame_cnt_q != 16'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt_q        <= '0;
      y_cnt_q        <= '0;
      line_w_q       <= '0;
      frame_width_q  <= '0;
      frame_height_q <= '0;
      frame_cnt_q    <= '0;
      geom_valid_q   <= 1'b0;
    end else begin
      x_cnt_q        <= x_cnt_d;
      y_cnt_q        <= y_cnt_d;
      line_w_q       <= line_w_d;
      frame_width_q  <= frame_width_d;
      frame_height_q <= frame_height_d;
      frame_cnt_q    <= frame_cnt_d;
      geom_valid_q   <= geom_valid_d;
    end
  end

  assign vid.de_out       = sync_s3_q.de;
  assign vid.h_sync_out   = sync_s3_q.hs;
  assign vid.v_sync_out   = sync_s3_q.vs;
  assign vid.pixel_out    = pix_s3_q;
  assign vid.frame_width  = frame_width_q;
  assign vid.frame_height = frame_height_q;
  assign vid.frame_cnt    = frame_cnt_q;
  assign vid.geom_valid   = geom_valid_q;

endmodule

// File: tb/tb_vp_pipe.sv
// Frame-level stimulus for vp_pipe with a queue scoreboard on the pixel stream
// and direct geometry checks after every frame start.
module tb_vp_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  vp_pipe_if #(.CH_W(8), .N_CH(3), .CNT_W(12)) vif ();

  vp_pipe #(.CH_W(8), .N_CH(3), .CNT_W(12), .THR_RST(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vid   (vif.slave)
  );

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] pix;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] dir[$];
  int          total = 0;
  int          bad = 0;
  bit          mon_en = 1'b0;

  logic [1:0]  m_mode;
  logic [7:0]  m_thr;
  logic        m_vs;
  int          g_cnt;
  int          last_w;
  int          last_h;
  int          frames = 0;

  // Reference pixel operation straight from the operation rules.
  function automatic logic [23:0] ref_px(logic [1:0] md, logic [7:0] th, logic [23:0] p);
    int r;
    int g;
    int b;
    int y;
    logic [7:0] y8;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    y = (77 * r + 150 * g + 29 * b) / 256;
    y8 = 8'(y);
    case (md)
      2'd0:    return p;
      2'd1:    return {y8, y8, y8};
      2'd2:    return (y8 >= th) ? 24'hFFFFFF : 24'h000000;
      default: return ~p;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic apply(logic de, logic hs, logic vs, logic [23:0] px, logic [1:0] md, logic [7:0] th);
    exp_t e;
    vif.de_in     = de;
    vif.h_sync_in = hs;
    vif.v_sync_in = vs;
    vif.pixel_in  = px;
    vif.mode      = md;
    vif.thr       = th;
    e.de  = de;
    e.hs  = hs;
    e.vs  = vs;
    e.pix = de ? ref_px(m_mode, m_thr, px) : 24'h0;
    exp_q.push_back(e);
    if (vs && !m_vs) begin
      m_mode = md;
      m_thr  = th;
    end
    m_vs = vs;
  endtask

  task automatic cyc(logic de, logic hs, logic vs, logic [23:0] px, logic [1:0] md, logic [7:0] th);
    @(posedge clk);
    #1;
    apply(de, hs, vs, px, md, th);
  endtask

  // Called #1 after a rising edge: release reset and prime the scoreboard with
  // the three cleared-pipeline outputs that precede the first real input.
  task automatic release_rst();
    rst_n  = 1'b1;
    m_mode = 2'd0;
    m_thr  = 8'd128;
    m_vs   = 1'b0;
    g_cnt  = 0;
    exp_q.delete();
    repeat (3) exp_q.push_back('0);
    apply(1'b0, 1'b0, 1'b0, 24'h0, vif.mode, vif.thr);
    mon_en = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("rst de_out", 32'(vif.de_out), 32'd0);
    chk("rst h_sync_out", 32'(vif.h_sync_out), 32'd0);
    chk("rst v_sync_out", 32'(vif.v_sync_out), 32'd0);
    chk("rst pixel_out", 32'(vif.pixel_out), 32'd0);
    chk("rst frame_width", 32'(vif.frame_width), 32'd0);
    chk("rst frame_height", 32'(vif.frame_height), 32'd0);
    chk("rst frame_cnt", 32'(vif.frame_cnt), 32'd0);
    chk("rst geom_valid", 32'(vif.geom_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    release_rst();
  endtask

  task automatic frame(int w, int h, logic [1:0] md, logic [7:0] th,
                       logic [1:0] mid_md, logic [7:0] mid_th, bit tail, int rst_line);
    logic [1:0]  cm;
    logic [7:0]  ct;
    logic [23:0] px;
    cm = md;
    ct = th;
    g_cnt++;
    cyc(1'b0, 1'b0, 1'b1, 24'($urandom), cm, ct);
    cyc(1'b0, 1'b0, 1'b1, 24'($urandom), cm, ct);
    cyc(1'b0, 1'b0, 1'b0, 24'($urandom), cm, ct);
    chk("frame_cnt", 32'(vif.frame_cnt), 32'(g_cnt[15:0]));
    chk("geom_valid", 32'(vif.geom_valid), (g_cnt >= 2) ? 32'd1 : 32'd0);
    if (g_cnt >= 2) begin
      chk("frame_width", 32'(vif.frame_width), 32'(last_w));
      chk("frame_height", 32'(vif.frame_height), 32'(last_h));
    end
    cyc(1'b0, 1'b0, 1'b0, 24'($urandom), cm, ct);
    for (int l = 0; l < h; l++) begin
      if (l == rst_line) do_reset();
      if (l == 1) begin
        cm = mid_md;
        ct = mid_th;
      end
      repeat (2) cyc(1'b0, 1'b1, 1'b0, 24'($urandom), cm, ct);
      repeat (2) cyc(1'b0, 1'b0, 1'b0, 24'($urandom), cm, ct);
      for (int p = 0; p < w; p++) begin
        px = (p < dir.size()) ? dir[p] : 24'($urandom);
        cyc(1'b1, 1'b0, 1'b0, px, cm, ct);
      end
      if (tail || (l != h - 1)) begin
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 24'($urandom), cm, ct);
      end
    end
    last_w = w;
    last_h = (rst_line >= 0) ? (h - rst_line) : h;
    frames++;
    $display("frame %0d: %0dx%0d mode=%0d thr=%0d mid_mode=%0d mid_thr=%0d reset_line=%0d bad=%0d",
             frames, w, h, md, th, mid_md, mid_th, rst_line, bad);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL stream: output present with empty scoreboard");
      end else begin
        e = exp_q.pop_front();
        if ({vif.de_out, vif.h_sync_out, vif.v_sync_out, vif.pixel_out} !== e) begin
          bad++;
          $display("FAIL stream: got de=%b hs=%b vs=%b pix=%h want de=%b hs=%b vs=%b pix=%h",
                   vif.de_out, vif.h_sync_out, vif.v_sync_out, vif.pixel_out,
                   e.de, e.hs, e.vs, e.pix);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vif.de_in     = 1'b0;
    vif.h_sync_in = 1'b0;
    vif.v_sync_in = 1'b0;
    vif.pixel_in  = 24'h0;
    vif.mode      = 2'd0;
    vif.thr       = 8'd128;
    last_w = 0;
    last_h = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("por frame_cnt", 32'(vif.frame_cnt), 32'd0);
    chk("por geom_valid", 32'(vif.geom_valid), 32'd0);
    chk("por pixel_out", 32'(vif.pixel_out), 32'd0);
    release_rst();

    dir = '{24'h123456};
    frame(64, 48, 2'd0, 8'd128, 2'd0, 8'd128, 1'b1, -1);
    dir = '{24'hFF0000, 24'hFFFFFF};
    frame(64, 48, 2'd1, 8'd128, 2'd2, 8'd50, 1'b0, -1);
    dir = '{24'h808080, 24'h7F7F7F, 24'hA0A0A0, 24'hC8C8C8};
    frame(64, 48, 2'd2, 8'd128, 2'd2, 8'd200, 1'b1, -1);
    dir = '{24'h0F0F0F};
    frame(16, 8, 2'd3, 8'd128, 2'd0, 8'd0, 1'b1, -1);
    dir = '{24'h000000, 24'h010101};
    frame(12, 3, 2'd2, 8'd0, 2'd1, 8'd255, 1'b1, -1);

    dir.delete();
    for (int i = 0; i < 6; i++) begin
      frame($urandom_range(4, 24), $urandom_range(2, 6), 2'($urandom_range(0, 3)), 8'($urandom),
            2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 1)), -1);
    end

    frame(64, 48, 2'd2, 8'd100, 2'd3, 8'd0, 1'b1, 20);
    frame(16, 8, 2'd1, 8'd90, 2'd3, 8'd10, 1'b1, -1);
    frame(20, 5, 2'd3, 8'd0, 2'd0, 8'd0, 1'b0, -1);
    frame(12, 4, 2'd2, 8'd60, 2'd1, 8'd0, 1'b1, -1);

    repeat (8) cyc(1'b0, 1'b0, 1'b0, 24'($urandom), 2'd0, 8'd0);
    @(negedge clk);
    #1;
    chk("scoreboard depth", 32'(exp_q.size()), 32'd3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vp_pipe.md
# vp_pipe

- Parametrised, mode-selectable successor to the fixed `vp` video processor; sits between the HDMI input and HDMI output stages on the pixel clock.
- Applies one of four per-frame pixel operations (pass, grayscale, binarise, invert) with a constant 3-cycle pipeline latency on pixel, `de`, `hsync` and `vsync`.
- Measures the incoming frame geometry (active width, active height, frame count).

## Interface
- `CH_W`, 8: bits per colour channel.
- `N_CH`, 3: number of channels; must be ≥ 3. The top three channels are R, G, B, matching the `{r,g,b}` packing.
- `CNT_W`, 12: width of the geometry counters.
- `THR_RST`, 128: threshold value after reset.
- `clk`, in, 1: pixel clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `de_in`, in, 1: data enable.
- `h_sync_in`, in, 1: horizontal sync.
- `v_sync_in`, in, 1: vertical sync, active high.
- `pixel_in`, in, `N_CH*CH_W`: input pixel.
- `mode`, in, 2: requested operation (0 pass, 1 gray, 2 binarise, 3 invert).
- `thr`, in, `CH_W`: binarisation threshold.
- `de_out`, `h_sync_out`, `v_sync_out`, out, 1 each: syncs delayed by 3 cycles.
- `pixel_out`, out, `N_CH*CH_W`: processed pixel.
- `frame_width`, out, `CNT_W`: active pixels in the last line of the previous frame.
- `frame_height`, out, `CNT_W`: active lines in the previous frame.
- `frame_cnt`, out, 16: number of frame starts seen since reset.
- `geom_valid`, out, 1: high once one complete frame has been measured.

## Operation
**Configuration latch**
- Frame start is a rising edge of `v_sync_in`, detected against a registered copy of `v_sync_in`.
- On frame start, `mode` and `thr` are captured into `mode_q` and `thr_q`. The captured values apply from the next input pixel onward.
- A `mode` or `thr` change in mid-frame has no effect until the next frame start.

**Luma**
- `Y = (77*R + 150*G + 29*B) >> 8`.
- Products are `CH_W+8` bits; the sum is `CH_W+10` bits.
- The coefficients sum to 256, so the result never exceeds `2^CH_W - 1`. No saturation logic.

**Per mode (output stage)**
- Pass: `pixel_out` equals `pixel_in`.
- Gray: every channel (including channels beyond 3) is `Y`.
- Binarise: every channel is all-ones if `Y >= thr_q`, else zero. `thr_q = 0` gives all-ones for every pixel.
- Invert: every channel is the bitwise NOT of its input.

**Blanking**
- When the pipelined `de` is low, `pixel_out` is 0 in every mode.

**Geometry**
- `x_cnt` counts cycles with `de_in` high.
- On a falling edge of `de_in`: `line_w <= x_cnt`, `y_cnt++`, `x_cnt <= 0`.
- On frame start: `frame_width <= line_w`, `frame_height <= y_cnt`, `y_cnt <= 0`, `frame_cnt++` (wraps at 2^16).
- `x_cnt` and `y_cnt` saturate at `2^CNT_W - 1`.
- `de_in` falling and `v_sync_in` rising in the same cycle: the line is counted first, so the captured height includes it.
- `geom_valid` rises at the second frame start after reset. The first frame after reset may be partial.

## Timing
- Latency is exactly 3 cycles from input to output for all signals and all modes. The mode changes only latency-aligned data.
- Pipeline stages:
  - S1 registers the inputs and the three products.
  - S2 registers the luma sum.
  - S3 registers the mode mux and the compare.
- Reset values:
  - All outputs 0, including `geom_valid` and `frame_cnt`.
  - `mode_q = 0` (pass).
  - `thr_q = THR_RST`.
  - Pipeline and counters cleared.
- Reset mid-frame: the outputs go to 0 asynchronously. After release, no output is valid until the pipeline refills (3 cycles). Geometry restarts from the first full frame.
- Geometry outputs update in the cycle after the frame-start edge and hold until the next frame start.

## Structure
- Package `vp_pkg`:
  - Mode encodings `VP_PASS`, `VP_GRAY`, `VP_BIN`, `VP_INV`.
  - Luma coefficients 77, 150, 29.
  - `VP_LAT = 3`.
- Sub-module `vp_luma`: 2-stage pipelined RGB→Y, parametrised on `CH_W`.
- The sync delay line, the config latch and the geometry counters stay in `vp_pipe`.

## Test plan
- **Pass:** mode 0, `CH_W=8`, pixel `0x123456` with `de` → `0x123456` out after exactly 3 cycles; `de`, `hsync` and `vsync` each delayed 3 cycles.
- **Gray:** mode 1, pixel `0xFF0000` → `0x4C4C4C`; pixel `0xFFFFFF` → `0xFFFFFF`.
- **Binarise:** mode 2, `thr=128`:
  - pixel `0x808080` → `0xFFFFFF`.
  - pixel `0x7F7F7F` → `0x000000`.
  - Change `thr` to 200 mid-frame → no effect until the next `vsync` rise.
- **Invert and blanking:** mode 3, pixel `0x0F0F0F` → `0xF0F0F0`; `de` low with nonzero `pixel_in` → `pixel_out` = 0.
- **Geometry:** 3 frames of 64×48 active → after the 2nd frame start `frame_width=64`, `frame_height=48`, `geom_valid=1`; `frame_cnt=3` after the 3rd.
- **Reset mid-frame:** assert `rst_n` low at line 20 → all outputs 0 and `mode_q` = pass; after release `geom_valid` stays 0 until the second frame start.
